// File: rtl/tff_add_bank_pkg.sv
// Shared types for the toggle-flip-flop scaled adder bank: FSM encoding and the
// per-bit output select used by every channel.
package tff_add_bank_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CH_DEF    = 4;
  localparam int LEN_W_DEF = 8;

  // Agreeing inputs pass straight through; disagreeing ones are arbitrated by the toggle.
  function automatic logic tff_sel(input logic a, input logic b, input logic q);
    return (a == b) ? a : q;
  endfunction

endpackage

// File: rtl/tff_add_cell.sv
// One channel of the scaled adder: toggle state Q, registered output y and the
// frame ones counter.
module tff_add_cell
  import tff_add_bank_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             ini,
  input  logic             accept,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             y,
  output logic [LEN_W-1:0] cnt
);

  logic             q_q, q_d;
  logic             y_q, y_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    q_d   = q_q;
    y_d   = y_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      q_d   = ini;
      cnt_d = '0;
    end else if (accept) begin
      y_d = tff_sel(a, b, q_q);
      if (a != b) begin
        q_d = ~q_q;
      end
      cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, y_d};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= 1'b0;
      y_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  assign y   = y_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/tff_add_bank.sv
// Bank of CH TFF scaled adders with a framing controller that counts output ones
// over a programmed length. Optional abort input enabled by TFF_ADD_BANK_ABORT_EN.
module tff_add_bank
  import tff_add_bank_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic [CH-1:0]       ini,
  input  logic                in_valid,
`ifdef TFF_ADD_BANK_ABORT_EN
  input  logic                abort,
`endif
  input  logic [CH-1:0]       a,
  input  logic [CH-1:0]       b,
  output logic [CH-1:0]       y,
  output logic                y_valid,
  output logic                busy,
  output logic                done,
  output logic [CH*LEN_W-1:0] cnt
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             y_valid_q, y_valid_d;
  logic             done_q, done_d;
  logic             load, accept, clr;
  logic             abort_w;

`ifdef TFF_ADD_BANK_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    y_valid_d = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
    accept    = 1'b0;
    clr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (len != '0)) begin
          load    = 1'b1;
          rem_d   = len;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over a sample presented on the same edge.
        if (abort_w) begin
          clr     = 1'b1;
          rem_d   = '0;
          state_d = S_IDLE;
        end else if (in_valid) begin
          accept    = 1'b1;
          y_valid_d = 1'b1;
          rem_d     = rem_q - 1'b1;
          if (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      y_valid_q <= y_valid_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = done_q;
  assign y_valid = y_valid_q;

  for (genvar i = 0; i < CH; i++) begin : g_cell
    tff_add_cell #(
      .LEN_W (LEN_W)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .ini    (ini[i]),
      .accept (accept),
      .clr    (clr),
      .a      (a[i]),
      .b      (b[i]),
      .y      (y[i]),
      .cnt    (cnt[i*LEN_W +: LEN_W])
    );
  end

endmodule

// File: tb/tb_tff_add_bank.sv
// Self-checking bench for tff_add_bank: table of frames with hand-derived ones counts,
// a y scoreboard, and hand sequences for reset, ignored starts and abort.
module tb_tff_add_bank;

  localparam int CH    = 4;
  localparam int LEN_W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [LEN_W-1:0]    len = '0;
  logic [CH-1:0]       ini = '0;
  logic                in_valid = 1'b0;
  logic [CH-1:0]       a = '0;
  logic [CH-1:0]       b = '0;
  logic [CH-1:0]       y;
  logic                y_valid, busy, done;
  logic [CH*LEN_W-1:0] cnt;
`ifdef TFF_ADD_BANK_ABORT_EN
  logic                abort = 1'b0;
`endif

  tff_add_bank #(.CH(CH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .ini      (ini),
    .in_valid (in_valid),
`ifdef TFF_ADD_BANK_ABORT_EN
    .abort    (abort),
`endif
    .a        (a),
    .b        (b),
    .y        (y),
    .y_valid  (y_valid),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               name;
    int                  flen;
    logic [CH-1:0]       fini;
    logic [CH-1:0]       fa;
    logic [CH-1:0]       fb;
    logic [31:0]         vmask;
    bit                  restart;
    bit                  rnd;
    logic [CH*LEN_W-1:0] exp_cnt;
  } case_t;

  int            n_pass = 0;
  int            n_total = 0;
  logic [CH-1:0] sb_q[$];
  logic [CH-1:0] mq;
  logic [CH-1:0] prev_y;
  int            m_cnt[CH];
  int            ones_ab[CH];
  case_t         cases[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic case_t mk(input string nm, input int l, input logic [CH-1:0] i,
                               input logic [CH-1:0] av, input logic [CH-1:0] bv,
                               input logic [31:0] vm, input bit rs, input bit rn,
                               input logic [CH*LEN_W-1:0] ec);
    case_t t;
    t.name = nm; t.flen = l; t.fini = i; t.fa = av; t.fb = bv;
    t.vmask = vm; t.restart = rs; t.rnd = rn; t.exp_cnt = ec;
    return t;
  endfunction

  task automatic model_init(input logic [CH-1:0] i);
    mq = i;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0;
      ones_ab[c] = 0;
    end
  endtask

  // Drive one cycle of a/b; a valid sample also pushes the expected y.
  task automatic drive(input logic [CH-1:0] av, input logic [CH-1:0] bv, input logic v);
    logic [CH-1:0] ym;
    a = av; b = bv; in_valid = v;
    if (v) begin
      for (int c = 0; c < CH; c++) begin
        if (av[c] == bv[c]) ym[c] = av[c];
        else begin
          ym[c] = mq[c];
          mq[c] = ~mq[c];
        end
        m_cnt[c] += int'(ym[c]);
        ones_ab[c] += int'(av[c]) + int'(bv[c]);
      end
      sb_q.push_back(ym);
    end
  endtask

  task automatic observe(input logic v);
    logic [CH-1:0] e;
    check("y_valid", 64'(y_valid), 64'(v));
    if (y_valid) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_empty: y_valid with no expected sample at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check("y", 64'(y), 64'(e));
      end
    end else begin
      check("y_hold", 64'(y), 64'(prev_y));
    end
    prev_y = y;
  endtask

  task automatic run_frame(input case_t tc);
    int samples, cyc, d;
    logic v;
    logic [CH-1:0] av, bv;
    logic [CH*LEN_W-1:0] exp_c;
    len = LEN_W'(tc.flen); ini = tc.fini; start = 1'b1;
    model_init(tc.fini);
    tick();
    check({tc.name, "_busy_start"}, 64'(busy), 64'd1);
    prev_y = y;
    start = tc.restart;
    if (tc.restart) begin
      len = LEN_W'(3);
      ini = ~tc.fini;
    end
    samples = 0;
    cyc = 0;
    while (samples < tc.flen && cyc < 4 * tc.flen + 20) begin
      if (tc.rnd) begin
        v = ($urandom_range(0, 3) != 0);
        av = CH'($urandom);
        bv = CH'($urandom);
      end else begin
        v = (tc.vmask == 32'd0) ? 1'b1 : tc.vmask[cyc % 32];
        av = v ? tc.fa : ~tc.fa;
        bv = v ? tc.fb : ~tc.fb;
      end
      drive(av, bv, v);
      tick();
      observe(v);
      if (v) samples++;
      cyc++;
      if (samples < tc.flen) check({tc.name, "_running"}, 64'({busy, done}), 64'b10);
    end
    if (samples < tc.flen) begin
      n_total++;
      $display("FAIL %s_budget: got %0d samples required %0d", tc.name, samples, tc.flen);
    end
    start = 1'b0;
    in_valid = 1'b0;
    check({tc.name, "_done"}, 64'({busy, done}), 64'b01);
    exp_c = tc.exp_cnt;
    if (tc.rnd) begin
      for (int c = 0; c < CH; c++) exp_c[c*LEN_W +: LEN_W] = LEN_W'(m_cnt[c]);
      for (int c = 0; c < CH; c++) begin
        d = 2 * int'(cnt[c*LEN_W +: LEN_W]) - ones_ab[c];
        check({tc.name, "_rate"}, 64'(d >= -2 && d <= 2), 64'd1);
      end
    end
    check({tc.name, "_cnt"}, 64'(cnt), 64'(exp_c));
    tick();
    check({tc.name, "_idle"}, 64'({busy, done, y_valid}), 64'b000);
  endtask

  initial begin
    cases[0]  = mk("agree_mix",  8, 4'b0000, 4'b0011, 4'b0101, 32'd0, 0, 0, {8'd0, 8'd4, 8'd4, 8'd8});
    cases[1]  = mk("ini1_len8",  8, 4'b1111, 4'b0011, 4'b0101, 32'd0, 0, 0, {8'd0, 8'd4, 8'd4, 8'd8});
    cases[2]  = mk("ini1_len7",  7, 4'b1111, 4'b0011, 4'b0101, 32'd0, 0, 0, {8'd0, 8'd4, 8'd4, 8'd7});
    cases[3]  = mk("ini0_len7",  7, 4'b0000, 4'b0011, 4'b0101, 32'd0, 0, 0, {8'd0, 8'd3, 8'd3, 8'd7});
    cases[4]  = mk("len1",       1, 4'b0010, 4'b0011, 4'b0101, 32'd0, 0, 0, {8'd0, 8'd0, 8'd1, 8'd1});
    cases[5]  = mk("stall",      4, 4'b0000, 4'b0011, 4'b0001, 32'h59, 0, 0, {8'd0, 8'd0, 8'd2, 8'd4});
    cases[6]  = mk("restart",    8, 4'b0000, 4'b0011, 4'b0101, 32'd0, 1, 0, {8'd0, 8'd4, 8'd4, 8'd8});
    cases[7]  = mk("max_agree",  255, 4'b0000, 4'b1111, 4'b1111, 32'd0, 0, 0, {8'd255, 8'd255, 8'd255, 8'd255});
    cases[8]  = mk("max_dis",    255, 4'b0100, 4'b0010, 4'b0100, 32'd0, 0, 0, {8'd0, 8'd128, 8'd127, 8'd0});
    cases[9]  = mk("len10",      10, 4'b0000, 4'b0011, 4'b0101, 32'd0, 0, 0, {8'd0, 8'd5, 8'd5, 8'd10});
    for (int i = 10; i < 14; i++)
      cases[i] = mk("rand", int'($urandom_range(1, 40)), CH'($urandom), '0, '0, 32'd0, 0, 1, '0);

    #1;
    check("reset_async", 64'({busy, done, y_valid, y, cnt}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("reset_state", 64'({busy, done, y_valid, y, cnt}), 64'd0);

    foreach (cases[i]) run_frame(cases[i]);

    // start with len==0 is ignored
    start = 1'b1; len = '0;
    tick();
    check("len0_busy", 64'(busy), 64'd0);
    start = 1'b0;
    tick();
    check("len0_idle", 64'({busy, done}), 64'b00);

    // start in DONE is ignored; accepted from the following edge
    start = 1'b1; len = 8'd1; ini = '0;
    model_init('0);
    tick();
    start = 1'b0;
    prev_y = y;
    drive(4'b1111, 4'b1111, 1'b1);
    tick();
    observe(1'b1);
    in_valid = 1'b0;
    check("short_done", 64'(done), 64'd1);
    start = 1'b1; len = 8'd2; ini = 4'b1111;
    tick();
    check("start_in_done", 64'({busy, done}), 64'b00);
    model_init(4'b1111);
    tick();
    check("start_after_done", 64'(busy), 64'd1);
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      drive(4'b0001, 4'b0010, 1'b1);
      tick();
      observe(1'b1);
    end
    in_valid = 1'b0;
    check("two_done", 64'({busy, done}), 64'b01);
    check("two_cnt", 64'(cnt), 64'({8'd0, 8'd0, 8'd1, 8'd1}));
    tick();

`ifdef TFF_ADD_BANK_ABORT_EN
    start = 1'b1; len = 8'd10; ini = '0;
    model_init('0);
    tick();
    start = 1'b0;
    prev_y = y;
    for (int s = 0; s < 3; s++) begin
      drive(4'b0011, 4'b0101, 1'b1);
      tick();
      observe(1'b1);
    end
    a = 4'b1111; b = 4'b1111; in_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_idle", 64'({busy, done, y_valid}), 64'b000);
    check("abort_cnt", 64'(cnt), 64'd0);
    tick();
    check("abort_no_done", 64'({busy, done}), 64'b00);
`endif

    // asynchronous reset in the middle of a frame
    start = 1'b1; len = 8'd8; ini = '0;
    model_init('0);
    tick();
    start = 1'b0;
    prev_y = y;
    for (int s = 0; s < 3; s++) begin
      drive(4'b0011, 4'b0001, 1'b1);
      tick();
      observe(1'b1);
    end
    in_valid = 1'b0;
    check("pre_reset_cnt0", 64'(cnt[LEN_W-1:0]), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("midframe_reset", 64'({busy, done, y_valid, y, cnt}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_reset_no_done", 64'({busy, done}), 64'b00);
    run_frame(mk("after_reset", 2, 4'b0000, 4'b0011, 4'b0101, 32'd0, 0, 0, {8'd0, 8'd1, 8'd1, 8'd2}));

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL sb_leftover: got %0d pending samples required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tff_add_bank.md
# tff_add_bank

Parametrised bank of CH toggle-flip-flop scaled adders for the stochastic MAC datapath. Each channel merges two input bitstreams into one stream whose ones-density is (pa+pb)/2, using a toggling state bit to alternate on disagreeing bits. A framing controller runs each channel for a programmed stream length and counts its output ones, so the result is available as a binary value. The block sits between the stream generators and the downstream accumulators.

## Interface
- CH, 4, number of independent adder channels
- LEN_W, 8, width of stream length and per-channel ones counters (max stream 2^LEN_W-1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin a frame (sampled only in IDLE)
- len  in  LEN_W  frame length in accepted samples, sampled with start
- ini  in  CH  per-channel initial toggle state, loaded on start
- in_valid  in  1  a/b carry a valid bit this cycle
- a, b  in  CH  input stream bits, one per channel
- y  out  CH  registered output stream bits
- y_valid  out  1  y holds a new sample
- busy  out  1  frame in progress (state RUN)
- done  out  1  one-cycle pulse, frame finished
- cnt  out  CH*LEN_W  per-channel ones count, channel i at [i*LEN_W +: LEN_W]

## Operation
- Reset is asynchronous and active-high. On reset: state IDLE, all Q=0, y=0, y_valid=0, busy=0, done=0, cnt=0, remaining=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and len!=0: Q<=ini, cnt<=0, remaining<=len, go to RUN.
  - start with len==0: ignored, stay in IDLE.
- RUN, per channel, on each cycle with in_valid=1:
  - a==b: y<=a, Q unchanged.
  - a!=b: y<=Q, Q<=~Q.
  - cnt_i<=cnt_i+y_next.
  - remaining decrements by 1.
  - When remaining==1 at the accepting edge, go to DONE.
- RUN with in_valid=0: Q, cnt, remaining and y hold; y_valid<=0.
- start in RUN or DONE is ignored.
- DONE: done=1 for exactly one cycle, then IDLE.
- cnt holds its final value until the next accepted start.
- Counter width: cnt_i ≤ len ≤ 2^LEN_W-1, so no overflow and no saturation logic.
- Rate rule: over a frame, |cnt_i − (ones(a_i)+ones(b_i))/2| ≤ 1.

## Timing
- start accepted at edge t: busy=1 from t; first sample can be accepted at edge t+1.
- Sample accepted at edge k: y and y_valid are visible after edge k (1-cycle latency). cnt includes that sample after edge k.
- Last sample at edge k: busy=0 and done=1 during the cycle after k; cnt is final at the same time. IDLE after edge k+1, and start is accepted from edge k+2.
- Reset asserted mid-frame: returns to IDLE immediately (async); no done pulse.

## Configuration
- TFF_ADD_BANK_ABORT_EN
  - Defined: adds input port abort (1 bit). abort=1 in RUN goes to IDLE at the next edge, cnt<=0, y_valid<=0, no done pulse. abort has priority over a sample accepted on the same edge. abort is ignored in IDLE and DONE.
  - Undefined: no abort port; a frame always runs to completion or reset.

## Structure
- Package tff_add_bank_pkg:
  - state encoding localparams S_IDLE, S_RUN, S_DONE.
- Sub-module tff_add_cell, instantiated CH times:
  - holds Q, y and cnt_i for one channel.
  - inputs: load, ini bit, accept, a, b.
  - the controller owns the FSM, remaining, y_valid and done.

## Test plan
- Reset: assert rst during RUN with cnt0=3 -> all outputs 0 at once, no done; new start len=2 then runs normally.
- Agree: CH0 a=b=1, len=8, ini=0, in_valid always 1 -> y0=1 for 8 samples, cnt0=8, done one cycle after the 8th accepting edge.
- Disagree: a=1, b=0, len=8, ini=0 -> y0 = 0,1,0,1,0,1,0,1, cnt0=4. With ini=1 -> y0 = 1,0,…, cnt0=4. With len=7, ini=1 -> cnt0=4.
- Stalls: len=4, in_valid = 1,0,0,1,1,0,1 -> y_valid pulses 4 times, done after the 7th cycle, Q unchanged in stall cycles.
- Ignored starts:
  - start with len=0 -> busy stays 0.
  - start during RUN -> frame length and cnt unaffected.
- Abort (macro defined): len=10, abort after 3 samples -> IDLE next cycle, cnt=0, no done. Macro undefined: the same frame completes with done.
